sram_ecc_scrubber: RTL
======================

Name: sram_ecc_scrubber

Overview:
Background scrubber for a 39/32 inverted-SECDED-protected single-port SRAM. It walks the address space, reads each word, and checks it with the inverted 39/32 SECDED decoder. Single-bit errors are written back re-encoded by prim_secded_inv_39_32_enc; double-bit errors are counted and logged. It shares the SRAM port with the host, and the host always has priority.

Parameters:
AW, 10, SRAM address width
DEPTH, 1024, number of words scrubbed per pass (≤ 2**AW)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  scrubbing enable (level)
interval_i  in  16  idle cycles between successive word scrubs
clr_i  in  1  synchronous clear of counters and uncorr_addr_o
host_req_i  in  1  host uses SRAM this cycle (priority)
host_we_i  in  1  host access is a write
host_addr_i  in  AW  host access address
mem_req_o  out  1  scrubber SRAM request (valid only when host_req_i=0)
mem_we_o  out  1  scrubber write
mem_addr_o  out  AW  scrubber address
mem_wdata_o  out  39  encoded write data
mem_rvalid_i  in  1  read data valid, exactly 1 cycle after an accepted read
mem_rdata_i  in  39  raw stored codeword
busy_o  out  1  FSM not in IDLE
pass_done_o  out  1  1-cycle pulse when word DEPTH-1 completes
corr_cnt_o  out  16  corrected single-bit errors, saturating
uncorr_cnt_o  out  16  uncorrectable errors, saturating
uncorr_addr_o  out  AW  address of most recent uncorrectable error

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, address pointer=0, wait counter=0, all outputs 0, cancel flag=0.
- States: IDLE -> WAIT -> READ -> RESP -> CHECK -> (WRITE) -> NEXT -> WAIT/IDLE.
- IDLE: when en_i=1, load wait counter with interval_i and go to WAIT.
- WAIT: decrement each cycle. At 0 go to READ. With interval_i=0, READ follows IDLE/NEXT after exactly 1 cycle.
- READ: mem_req_o=!host_req_i, mem_we_o=0, mem_addr_o=pointer.
  - Read is accepted the cycle mem_req_o=1; go to RESP.
  - Host stall may last indefinitely; stay in READ.
- RESP: wait for mem_rvalid_i, then capture mem_rdata_i into a register; go to CHECK.
- CHECK: the registered codeword goes through the decoder. Decoder XORs 39'h2A00000000, then computes syndrome and single/double flags.
  - Clean: go to NEXT.
  - Single error: mem_wdata_o = encoder(corrected data[31:0]), registered. corr_cnt_o +1; go to WRITE.
  - Double error: uncorr_cnt_o +1, uncorr_addr_o=pointer; go to NEXT with no write.
- WRITE: mem_req_o=!host_req_i && !cancel, mem_we_o=1. Accepted write goes to NEXT. If cancel=1, go to NEXT without requesting.
- Cancel: set if host_req_i && host_we_i && host_addr_i==pointer in any cycle from read acceptance through WRITE. Cleared in NEXT. Host data must never be overwritten by stale correction.
- NEXT: pointer = (pointer==DEPTH-1) ? 0 : pointer+1.
  - On wrap, pulse pass_done_o for 1 cycle.
  - If en_i=1, reload interval_i and go to WAIT; else go to IDLE.
- en_i deasserted mid-word: the current word completes through NEXT, including any pending write. Pointer is retained for resume.
- Counters saturate at 16'hFFFF.
- clr_i zeros both counters and uncorr_addr_o; clr_i wins over a simultaneous increment.
- mem_req_o must be 0 in every cycle host_req_i=1 (combinational gate).
- mem_addr_o and mem_wdata_o are held stable during stalls.

Test Plan:
- All words 39'h2A00000000 (encoded zero), DEPTH=4, interval_i=0, en_i=1 -> no writes; corr/uncorr stay 0; pass_done_o pulses once per 4 words, then address wraps to 0.
- Word 2 = 39'h2A00000001 -> one write to addr 2 with data 39'h2A00000000; corr_cnt_o=1.
- Word 1 = 39'h2A00000003 -> no write; uncorr_cnt_o=1, uncorr_addr_o=1; word unchanged.
- host_req_i held high for 20 cycles while FSM in READ -> mem_req_o=0 throughout; read issued the cycle host_req_i drops.
- Single error at addr 3, host write to addr 3 in the CHECK cycle -> no scrubber write; corr_cnt_o still 1. Host write to addr 0 at the same point -> writeback still occurs.
- Preload corr_cnt to 16'hFFFF (force) plus another single error -> stays 16'hFFFF. Assert clr_i -> 0. rst_ni low mid-WRITE -> mem_req_o=0 immediately, busy_o=0.

Source files
------------

// File: rtl/sram_ecc_scrubber.sv
// Background scrubber for an inverted 39/32 SECDED single-port SRAM.
// Walks the address space, rewrites single-bit errors, logs double-bit errors; host always wins the port.
module sram_ecc_scrubber #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [15:0]   interval_i,
  input  logic          clr_i,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [38:0]   mem_wdata_o,
  input  logic          mem_rvalid_i,
  input  logic [38:0]   mem_rdata_i,
  output logic          busy_o,
  output logic          pass_done_o,
  output logic [15:0]   corr_cnt_o,
  output logic [15:0]   uncorr_cnt_o,
  output logic [AW-1:0] uncorr_addr_o
);

  localparam logic [38:0]      INV_MASK = 39'h2A00000000;
  localparam logic [AW-1:0]    LAST     = AW'(DEPTH - 1);
  // Row k selects the data bits covered by check bit 32+k (Hsiao 39/32 code).
  localparam logic [6:0][31:0] H = {
    32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
    32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
  };

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_RESP, S_CHECK, S_WRITE, S_NEXT
  } state_e;

  state_e        state_reg;
  logic [AW-1:0] ptr_reg;
  logic [15:0]   wait_cnt_reg;
  logic [38:0]   rdata_reg;
  logic [38:0]   wdata_reg;
  logic          cancel_reg;
  logic          pass_done_reg;
  logic [15:0]   corr_cnt_reg;
  logic [15:0]   uncorr_cnt_reg;
  logic [AW-1:0] uncorr_addr_reg;

  function automatic logic [38:0] enc_inv(input logic [31:0] d);
    logic [38:0] c;
    c = {7'b0, d};
    for (int k = 0; k < 7; k++) begin
      c[32+k] = ^(d & H[k]);
    end
    return c ^ INV_MASK;
  endfunction

  logic [38:0] code;
  logic [6:0]  syn;
  logic [31:0] data_fix;
  logic        single_err;
  logic        double_err;

  assign code = rdata_reg ^ INV_MASK;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_syn
      assign syn[gi] = (^(code[31:0] & H[gi])) ^ code[32+gi];
    end
    for (gi = 0; gi < 32; gi++) begin : g_fix
      localparam logic [6:0] COL = {H[6][gi], H[5][gi], H[4][gi], H[3][gi],
                                    H[2][gi], H[1][gi], H[0][gi]};
      assign data_fix[gi] = code[gi] ^ (syn == COL);
    end
  endgenerate

  assign single_err = ^syn;
  assign double_err = (|syn) & ~(^syn);

  // Host may overwrite the word between read acceptance and writeback; that aborts the writeback.
  logic in_window;
  logic host_hit;
  assign in_window = (state_reg == S_RESP) || (state_reg == S_CHECK) || (state_reg == S_WRITE);
  assign host_hit  = host_req_i && host_we_i && (host_addr_i == ptr_reg);

  assign mem_req_o     = !host_req_i &&
                         ((state_reg == S_READ) || ((state_reg == S_WRITE) && !cancel_reg));
  assign mem_we_o      = (state_reg == S_WRITE);
  assign mem_addr_o    = ptr_reg;
  assign mem_wdata_o   = wdata_reg;
  assign busy_o        = (state_reg != S_IDLE);
  assign pass_done_o   = pass_done_reg;
  assign corr_cnt_o    = corr_cnt_reg;
  assign uncorr_cnt_o  = uncorr_cnt_reg;
  assign uncorr_addr_o = uncorr_addr_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      wait_cnt_reg    <= '0;
      rdata_reg       <= '0;
      wdata_reg       <= '0;
      cancel_reg      <= 1'b0;
      pass_done_reg   <= 1'b0;
      corr_cnt_reg    <= '0;
      uncorr_cnt_reg  <= '0;
      uncorr_addr_reg <= '0;
    end else begin
      pass_done_reg <= 1'b0;
      if (in_window && host_hit) cancel_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (en_i) begin
            wait_cnt_reg <= interval_i;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // No access has started yet, so disabling here just parks at the current pointer.
          if (!en_i)                   state_reg    <= S_IDLE;
          else if (wait_cnt_reg == '0) state_reg    <= S_READ;
          else                         wait_cnt_reg <= wait_cnt_reg - 16'd1;
        end
        S_READ: begin
          if (mem_req_o) state_reg <= S_RESP;
        end
        S_RESP: begin
          if (mem_rvalid_i) begin
            rdata_reg <= mem_rdata_i;
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (single_err) begin
            wdata_reg <= enc_inv(data_fix);
            state_reg <= S_WRITE;
          end else begin
            state_reg <= S_NEXT;
          end
        end
        S_WRITE: begin
          if (cancel_reg || mem_req_o) state_reg <= S_NEXT;
        end
        S_NEXT: begin
          cancel_reg    <= 1'b0;
          ptr_reg       <= (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
          pass_done_reg <= (ptr_reg == LAST);
          if (en_i) begin
            wait_cnt_reg <= interval_i;
            state_reg    <= S_WAIT;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      if (clr_i) begin
        corr_cnt_reg    <= '0;
        uncorr_cnt_reg  <= '0;
        uncorr_addr_reg <= '0;
      end else if (state_reg == S_CHECK) begin
        if (single_err && (corr_cnt_reg != 16'hFFFF)) corr_cnt_reg <= corr_cnt_reg + 16'd1;
        if (double_err) begin
          if (uncorr_cnt_reg != 16'hFFFF) uncorr_cnt_reg <= uncorr_cnt_reg + 16'd1;
          uncorr_addr_reg <= ptr_reg;
        end
      end
    end
  end

endmodule
